// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Receives a byte stream over a valid/ready handshake, assembles big-endian
// 32-bit instruction words (first byte lands in [31:24]) and writes them to
// consecutive word addresses starting at 0. While a load is in progress,
// busy holds the core in stall.
//
// Parameters:
//   ADDR_W  word-address width of the instruction memory
//   DEPTH   number of instruction words; must equal 2**ADDR_W
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse to begin a load (sampled only in IDLE)
//   word_count  number of words to load, latched on an accepted start
//   byte_valid  byte_data is valid this cycle
//   byte_data   program byte, MSB of each word first
//   byte_ready  loader accepts a byte this cycle
//   we          instruction memory write enable, one cycle per word
//   waddr       instruction memory word address
//   wdata       instruction word being written (valid when we=1)
//   busy        load in progress
//   done        one-cycle pulse when a load completes
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     target_reg;
  logic [ADDR_W:0]     word_cnt_reg;
  logic [1:0]          byte_cnt_reg;
  // Only the first three bytes of a word need holding; the fourth goes
  // straight into wdata_reg together with them.
  logic [23:0]         asm_reg;
  logic [ADDR_W-1:0]   waddr_reg;
  logic [31:0]         wdata_reg;

  logic [ADDR_W:0]     target_clamped;
  logic                xfer;
  logic                last_word;

  // Clamping to DEPTH is what keeps waddr from ever wrapping.
  assign target_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign xfer           = (state_reg == RECV) && byte_valid;
  assign last_word      = ((word_cnt_reg + ONE_W) == target_reg);

  // Outputs are pure decodes of the state, so reset forces them low at once.
  assign byte_ready = (state_reg == RECV);
  assign we         = (state_reg == WRITE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign waddr      = waddr_reg;
  assign wdata      = wdata_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (target_clamped == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (xfer && (byte_cnt_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_word ? DONE : RECV;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      target_reg   <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            target_reg   <= target_clamped;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            waddr_reg    <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            asm_reg      <= {asm_reg[15:0], byte_data};
            if (byte_cnt_reg == 2'd3) begin
              wdata_reg <= {asm_reg, byte_data};
            end
          end
        end
        WRITE: begin
          word_cnt_reg <= word_cnt_reg + ONE_W;
          // The final word leaves waddr pointing at the last address written.
          if (!last_word) begin
            waddr_reg <= waddr_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int timeout_cnt = 0;

  // Observation only: record what the DUT does, tasks compare against it.
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int done_cnt, done_cyc, hs_cnt, hs_last_cyc, br_cnt, ovl_cnt;

  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(int'(waddr));
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (byte_valid && byte_ready) begin
      hs_cnt++;
      hs_last_cyc = cyc;
    end
    if (byte_ready) br_cnt++;
    if (we && byte_ready) ovl_cnt++;
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0; done_cyc = -1; hs_cnt = 0; hs_last_cyc = -1;
    br_cnt = 0; ovl_cnt = 0; timeout_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int wc, output int sc);
    start = 1'b1;
    word_count = (ADDR_W + 1)'(wc);
    step();
    start = 1'b0;
    sc = cyc;
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    byte_valid = 1'b0;
    if (!ok) timeout_cnt++;
  endtask

  task automatic load_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) step();
      push_byte(w[31 - 8 * k -: 8]);
    end
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    step();
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return {v[7:0], v[15:8] ^ 8'hA5, 8'(i * 3), 8'h5C};
  endfunction

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({byte_ready, we, busy, done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {byte_ready, we, busy, done});
    end
    n_cmp++;
    if (waddr !== '0 || wdata !== '0) begin
      n_bad++; $display("FAIL reset_data: waddr=%0d wdata=%h want 0/0", waddr, wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy=%b byte_ready=%b want 0/0", busy, byte_ready);
    end
    $display("test_reset: checked reset and idle outputs");
  endtask

  task automatic test_single();
    int sc; bit got;
    clear_mon();
    pulse_start(1, sc);
    load_word(32'h20100001, 0);
    wait_done(20, got);
    n_cmp++;
    if (!got || timeout_cnt != 0) begin
      n_bad++; $display("FAIL single_done: got=%0d timeouts=%0d want 1/0", got, timeout_cnt);
    end
    n_cmp++;
    if (wa_q.size() != 1) begin
      n_bad++; $display("FAIL single_nwrites: got %0d want 1", wa_q.size());
    end
    n_cmp++;
    if (wa_q[0] != 0 || wd_q[0] !== 32'h20100001) begin
      n_bad++; $display("FAIL single_write: addr=%0d data=%h want 0/20100001", wa_q[0], wd_q[0]);
    end
    n_cmp++;
    if (wc_q[0] != hs_last_cyc + 1) begin
      n_bad++; $display("FAIL single_we_latency: we cyc=%0d want %0d", wc_q[0], hs_last_cyc + 1);
    end
    n_cmp++;
    if (done_cyc != wc_q[0] + 1) begin
      n_bad++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, wc_q[0] + 1);
    end
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      n_bad++; $display("FAIL single_after: busy=%b done_cnt=%0d want 0/1", busy, done_cnt);
    end
    $display("test_single: load of 1 word, write addr=%0d data=%h", wa_q[0], wd_q[0]);
  endtask

  task automatic test_multi();
    int sc; bit got;
    logic [31:0] words [3];
    words[0] = 32'h20100001; words[1] = 32'h012A4820; words[2] = 32'h20100006;
    clear_mon();
    pulse_start(3, sc);
    for (int i = 0; i < 3; i++) load_word(words[i], 0);
    wait_done(20, got);
    n_cmp++;
    if (!got || wa_q.size() != 3 || done_cnt != 1) begin
      n_bad++; $display("FAIL multi_counts: done=%0d writes=%0d dones=%0d want 1/3/1", got, wa_q.size(), done_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wa_q[i] != i || wd_q[i] !== words[i]) begin
        n_bad++; $display("FAIL multi_write%0d: addr=%0d data=%h want %0d/%h", i, wa_q[i], wd_q[i], i, words[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (wc_q[i] - wc_q[i-1] != 5) begin
        n_bad++; $display("FAIL multi_spacing%0d: got %0d want 5", i, wc_q[i] - wc_q[i-1]);
      end
    end
    $display("test_multi: 3 words, %0d writes, %0d done pulses", wa_q.size(), done_cnt);
  endtask

  task automatic test_gaps();
    int sc; bit got;
    logic [31:0] words [2];
    words[0] = 32'hCAFEBABE; words[1] = 32'h13572468;
    clear_mon();
    pulse_start(2, sc);
    for (int i = 0; i < 2; i++) load_word(words[i], 2);
    wait_done(20, got);
    n_cmp++;
    if (!got || wa_q.size() != 2 || timeout_cnt != 0) begin
      n_bad++; $display("FAIL gaps_counts: done=%0d writes=%0d timeouts=%0d want 1/2/0", got, wa_q.size(), timeout_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (wa_q[i] != i || wd_q[i] !== words[i]) begin
        n_bad++; $display("FAIL gaps_write%0d: addr=%0d data=%h want %0d/%h", i, wa_q[i], wd_q[i], i, words[i]);
      end
    end
    n_cmp++;
    if (hs_cnt != 8 || ovl_cnt != 0) begin
      n_bad++; $display("FAIL gaps_handshake: hs=%0d overlap=%0d want 8/0", hs_cnt, ovl_cnt);
    end
    $display("test_gaps: 2 words with gaps, %0d handshakes", hs_cnt);
  endtask

  task automatic test_zero();
    int sc;
    clear_mon();
    pulse_start(0, sc);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    repeat (5) step();
    byte_valid = 1'b0;
    n_cmp++;
    if (wa_q.size() != 0 || done_cnt != 1) begin
      n_bad++; $display("FAIL zero_counts: writes=%0d dones=%0d want 0/1", wa_q.size(), done_cnt);
    end
    n_cmp++;
    if (done_cyc < sc || done_cyc > sc + 2) begin
      n_bad++; $display("FAIL zero_done_cyc: got %0d want %0d..%0d", done_cyc, sc, sc + 2);
    end
    n_cmp++;
    if (br_cnt != 0 || hs_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_ready: br=%0d hs=%0d busy=%b want 0/0/0", br_cnt, hs_cnt, busy);
    end
    $display("test_zero: word_count=0, done after %0d cycles", done_cyc - sc);
  endtask

  task automatic test_full();
    int sc, bad_w; bit got;
    clear_mon();
    pulse_start(1100, sc);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 300 || i == 700) begin
        start = 1'b1;
        word_count = (ADDR_W + 1)'(5);
      end
      load_word(pat(i), 0);
      start = 1'b0;
    end
    wait_done(20, got);
    n_cmp++;
    if (!got || wa_q.size() != DEPTH || done_cnt != 1 || timeout_cnt != 0) begin
      n_bad++; $display("FAIL full_counts: done=%0d writes=%0d dones=%0d timeouts=%0d want 1/1024/1/0",
                        got, wa_q.size(), done_cnt, timeout_cnt);
    end
    bad_w = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] != i || wd_q[i] !== pat(i)) bad_w++;
    end
    n_cmp++;
    if (bad_w != 0) begin
      n_bad++; $display("FAIL full_data: %0d wrong writes want 0", bad_w);
    end
    n_cmp++;
    if (wa_q[wa_q.size() - 1] != DEPTH - 1 || waddr !== 10'd1023) begin
      n_bad++; $display("FAIL full_last_addr: got %0d/%0d want 1023", wa_q[wa_q.size() - 1], waddr);
    end
    $display("test_full: word_count=1100, %0d writes, %0d bad", wa_q.size(), bad_w);
  endtask

  task automatic test_reset_mid();
    int sc; bit got;
    clear_mon();
    pulse_start(3, sc);
    load_word(32'h11223344, 0);
    push_byte(8'h55);
    push_byte(8'h66);
    n_cmp++;
    if (wa_q.size() != 1 || done_cnt != 0) begin
      n_bad++; $display("FAIL mid_before: writes=%0d dones=%0d want 1/0", wa_q.size(), done_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, we, busy, done} !== 4'b0000 || waddr !== '0 || wdata !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: ctrl=%b waddr=%0d wdata=%h want 0000/0/0",
                        {byte_ready, we, busy, done}, waddr, wdata);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (done_cnt != 0) begin
      n_bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt);
    end
    clear_mon();
    pulse_start(1, sc);
    load_word(32'hDEADBEEF, 0);
    wait_done(20, got);
    n_cmp++;
    if (!got || wa_q.size() != 1 || wa_q[0] != 0 || wd_q[0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL mid_reload: done=%0d writes=%0d addr=%0d data=%h want 1/1/0/deadbeef",
                        got, wa_q.size(), wa_q[0], wd_q[0]);
    end
    $display("test_reset_mid: reload write addr=%0d data=%h", wa_q[0], wd_q[0]);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_multi();
    test_gaps();
    test_zero();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
